// File: rtl/elastic_memory_port_pkg.sv
// Shared widths, default load latency and FSM state encoding for the elastic memory port.
package elastic_memory_port_pkg;

    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ADDRESS_WIDTH = 16;
    localparam int unsigned LOAD_CYCLE    = 2;
    localparam int unsigned CNT_WIDTH     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        RESPOND = 2'b10
    } state_e;

endpackage

// File: rtl/elastic_memory_array.sv
// Word storage: synchronous write, combinational read, no reset so contents survive reset_n.
module elastic_memory_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/elastic_memory_port.sv
// Valid/stop memory port: stores complete in one cycle, loads answer after LOAD_LATENCY cycles.
module elastic_memory_port #(
    parameter int unsigned DATA_WIDTH    = elastic_memory_port_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = elastic_memory_port_pkg::ADDRESS_WIDTH,
    parameter int unsigned MEM_DEPTH     = 1024,
    parameter int unsigned LOAD_LATENCY  = elastic_memory_port_pkg::LOAD_CYCLE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_stop,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_write_data,
    output logic                     resp_valid,
    input  logic                     resp_stop,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     error
);

    import elastic_memory_port_pkg::state_e;
    import elastic_memory_port_pkg::IDLE;
    import elastic_memory_port_pkg::WAIT;
    import elastic_memory_port_pkg::RESPOND;
    import elastic_memory_port_pkg::CNT_WIDTH;

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e                   r_state, w_state_next;
    logic [CNT_WIDTH-1:0]     r_cnt, w_cnt_next;
    logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_next;
    logic                     r_oor, w_oor_next;
    logic [DATA_WIDTH-1:0]    r_resp_data, w_resp_data_next;
    logic                     r_error, w_error_next;
    logic                     r_req_stop, r_resp_valid;

    logic                     w_req_xfer, w_resp_xfer, w_req_oor, w_wr_en, w_rd_oor;
    logic [ADDRESS_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0]    w_rd_data, w_load_value;

    assign w_req_xfer  = req_valid & ~r_req_stop;
    assign w_resp_xfer = r_resp_valid & ~resp_stop;
    assign w_req_oor   = ({1'b0, req_address} >= (ADDRESS_WIDTH + 1)'(MEM_DEPTH));
    assign w_wr_en     = w_req_xfer & req_write & ~w_req_oor;

    // With a one-cycle latency the read happens on the accepting edge, so bypass the latch.
    assign w_rd_addr    = (r_state == IDLE) ? req_address : r_addr;
    assign w_rd_oor     = (r_state == IDLE) ? w_req_oor : r_oor;
    assign w_load_value = w_rd_oor ? '0 : w_rd_data;

    elastic_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (IDX_W'(req_address)),
        .i_wr_data (req_write_data),
        .i_rd_idx  (IDX_W'(w_rd_addr)),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_addr_next      = r_addr;
        w_oor_next       = r_oor;
        w_resp_data_next = r_resp_data;
        w_error_next     = r_error;

        if (w_req_xfer && w_req_oor) begin
            w_error_next = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_req_xfer && !req_write) begin
                    w_addr_next = req_address;
                    w_oor_next  = w_req_oor;
                    if (LOAD_LATENCY == 1) begin
                        w_state_next     = RESPOND;
                        w_resp_data_next = w_load_value;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_WIDTH'(LOAD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == CNT_WIDTH'(1)) begin
                    w_state_next     = RESPOND;
                    w_cnt_next       = '0;
                    w_resp_data_next = w_load_value;
                end else begin
                    w_cnt_next = r_cnt - CNT_WIDTH'(1);
                end
            end
            RESPOND: begin
                if (w_resp_xfer) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_oor        <= 1'b0;
            r_resp_data  <= '0;
            r_error      <= 1'b0;
            r_req_stop   <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_addr       <= w_addr_next;
            r_oor        <= w_oor_next;
            r_resp_data  <= w_resp_data_next;
            r_error      <= w_error_next;
            r_req_stop   <= (w_state_next != IDLE);
            r_resp_valid <= (w_state_next == RESPOND);
        end
    end

    assign req_stop   = r_req_stop;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign error      = r_error;

endmodule

// File: tb/tb_elastic_memory_port.sv
// Directed bench: LOAD_LATENCY=2 instance for most scenarios, LOAD_LATENCY=1 instance for throughput.
module tb_elastic_memory_port;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0, req_write = 1'b0, resp_stop = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [DW-1:0] req_write_data = '0;
    logic          req_stop, resp_valid, error;
    logic [DW-1:0] resp_data;

    logic          req_valid_b = 1'b0, req_write_b = 1'b0, resp_stop_b = 1'b0;
    logic [AW-1:0] req_address_b = '0;
    logic [DW-1:0] req_write_data_b = '0;
    logic          req_stop_b, resp_valid_b, error_b;
    logic [DW-1:0] resp_data_b;

    int total = 0;
    int bad = 0;

    elastic_memory_port #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH(1024), .LOAD_LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_stop(req_stop),
        .req_write(req_write), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_stop(resp_stop), .resp_data(resp_data), .error(error)
    );

    elastic_memory_port #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH(1024), .LOAD_LATENCY(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_stop(req_stop_b),
        .req_write(req_write_b), .req_address(req_address_b), .req_write_data(req_write_data_b),
        .resp_valid(resp_valid_b), .resp_stop(resp_stop_b), .resp_data(resp_data_b), .error(error_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic store_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid = 1'b1; req_write = 1'b1; req_address = addr; req_write_data = data;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic load_a(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output int lat, output bit ok);
        req_valid = 1'b1; req_write = 1'b0; req_address = addr;
        tick();
        req_valid = 1'b0;
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
        data = resp_data;
        if (ok) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        total++; if (req_stop !== 1'b0)   begin bad++; $display("FAIL reset_req_stop got=%b want=0", req_stop); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        total++; if (resp_data !== '0)    begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        total++; if (error !== 1'b0)      begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if ({req_stop_b, resp_valid_b, error_b} !== 3'b000 || resp_data_b !== '0) begin
            bad++; $display("FAIL reset_b got=%b%b%b/%h want=000/0", req_stop_b, resp_valid_b, error_b, resp_data_b);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_raw();
        store_a(16'd5, 32'h0000_00AA);
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'd5;
        total++; if (req_stop !== 1'b0) begin bad++; $display("FAIL raw_accept_stop got=%b want=0", req_stop); end
        tick();
        req_valid = 1'b0;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL raw_wait_valid got=%b want=0", resp_valid); end
        total++; if (req_stop !== 1'b1)   begin bad++; $display("FAIL raw_wait_stop got=%b want=1", req_stop); end
        tick();
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL raw_resp_valid got=%b want=1", resp_valid); end
        total++; if (resp_data !== 32'h0000_00AA) begin bad++; $display("FAIL raw_resp_data got=%h want=000000aa", resp_data); end
        tick();
        total++; if (resp_valid !== 1'b0 || req_stop !== 1'b0) begin
            bad++; $display("FAIL raw_idle valid/stop got=%b/%b want=0/0", resp_valid, req_stop);
        end
    endtask

    task automatic test_stall();
        bit seen = 1'b0;
        resp_stop = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'd5;
        tick();
        // Stalled store attempt must not be sampled while req_stop is high.
        req_valid = 1'b1; req_write = 1'b1; req_address = 16'd5; req_write_data = 32'h0000_0BAD;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin seen = 1'b1; break; end
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL stall_timeout got=0 want=resp_valid"); end
        for (int k = 0; k < 4; k++) begin
            total++; if (resp_valid !== 1'b1 || resp_data !== 32'h0000_00AA || req_stop !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d valid/data/stop got=%b/%h/%b want=1/000000aa/1", k, resp_valid, resp_data, req_stop);
            end
            tick();
        end
        req_valid = 1'b0; req_write = 1'b0;
        resp_stop = 1'b0;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL stall_release_valid got=%b want=1", resp_valid); end
        tick();
        total++; if (resp_valid !== 1'b0 || req_stop !== 1'b0) begin
            bad++; $display("FAIL stall_idle valid/stop got=%b/%b want=0/0", resp_valid, req_stop);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        int lat;
        bit ok;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_address = AW'(i); req_write_data = DW'(10 * i);
            total++; if (req_stop !== 1'b0) begin bad++; $display("FAIL b2b_stop%0d got=%b want=0", i, req_stop); end
            tick();
        end
        req_valid = 1'b0; req_write = 1'b0;
        total++; if (req_stop !== 1'b0) begin bad++; $display("FAIL b2b_stop_end got=%b want=0", req_stop); end
        for (int i = 1; i <= 3; i++) begin
            load_a(AW'(i), d, lat, ok);
            total++; if (!ok || d !== DW'(10 * i) || lat != 2) begin
                bad++; $display("FAIL b2b_load%0d ok/data/lat got=%0d/%0d/%0d want=1/%0d/2", i, ok, d, lat, 10 * i);
            end
        end
    endtask

    task automatic test_error();
        logic [DW-1:0] d;
        int lat;
        bit ok;
        total++; if (error !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", error); end
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'd1024;
        tick();
        req_valid = 1'b0;
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", error); end
        tick();
        total++; if (resp_valid !== 1'b1 || resp_data !== '0) begin
            bad++; $display("FAIL err_load valid/data got=%b/%h want=1/0", resp_valid, resp_data);
        end
        tick();
        store_a(16'd0, 32'h0000_0055);
        store_a(16'd1024, 32'h0000_DEAD);
        load_a(16'd0, d, lat, ok);
        total++; if (!ok || d !== 32'h0000_0055) begin
            bad++; $display("FAIL err_discard ok/data got=%0d/%h want=1/00000055", ok, d);
        end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", error); end
    endtask

    task automatic test_reset_wait();
        logic [DW-1:0] d;
        int lat;
        bit ok;
        bit leak = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_address = 16'd5;
        tick();
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0 || req_stop !== 1'b0 || error !== 1'b0) begin
            bad++; $display("FAIL rstw_async valid/stop/err got=%b/%b/%b want=0/0/0", resp_valid, req_stop, error);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid !== 1'b0) leak = 1'b1;
        end
        total++; if (leak) begin bad++; $display("FAIL rstw_leak got=1 want=0"); end
        load_a(16'd5, d, lat, ok);
        total++; if (!ok || d !== 32'h0000_00AA) begin
            bad++; $display("FAIL rstw_retain ok/data got=%0d/%h want=1/000000aa", ok, d);
        end
    endtask

    task automatic test_latency1();
        int resps = 0;
        req_valid_b = 1'b1; req_write_b = 1'b1; req_address_b = 16'd9; req_write_data_b = 32'h0000_0099;
        tick();
        req_write_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (resp_valid_b) resps++;
            total++; if (resp_valid_b !== ((c % 2) == 0)) begin
                bad++; $display("FAIL lat1_valid c%0d got=%b want=%0d", c, resp_valid_b, (c % 2) == 0);
            end
            if ((c % 2) == 0) begin
                total++; if (resp_data_b !== 32'h0000_0099) begin
                    bad++; $display("FAIL lat1_data c%0d got=%h want=00000099", c, resp_data_b);
                end
            end
        end
        req_valid_b = 1'b0;
        total++; if (resps != 4) begin bad++; $display("FAIL lat1_count got=%0d want=4", resps); end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_stall();
        test_back_to_back();
        test_error();
        test_reset_wait();
        test_latency1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elastic_memory_port.md
ELASTIC_MEMORY_PORT -- requirements
Module: elastic_memory_port

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of data words.
REQ-002 Parameter ADDRESS_WIDTH, default 16, width of request address.
REQ-003 Parameter MEM_DEPTH, default 1024, number of words stored; legal range 1..2**ADDRESS_WIDTH.
REQ-004 Parameter LOAD_LATENCY, default LOAD_CYCLE (2), cycles from load acceptance to response valid; legal range 1..255.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  SELF valid for request token.
REQ-008 req_stop  output  1  SELF stop toward requester.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_address  input  ADDRESS_WIDTH  word address.
REQ-011 req_write_data  input  DATA_WIDTH  store data.
REQ-012 resp_valid  output  1  SELF valid for load-response token.
REQ-013 resp_stop  input  1  SELF stop from response consumer.
REQ-014 resp_data  output  DATA_WIDTH  load result, registered.
REQ-015 error  output  1  sticky flag, out-of-range access seen.

Function
REQ-016 Request transfer SHALL be req_valid & !req_stop; response transfer SHALL be resp_valid & !resp_stop.
REQ-017 FSM states SHALL be IDLE, WAIT, RESPOND; req_stop = (state != IDLE); resp_valid = (state == RESPOND).
REQ-018 Store transfer in IDLE SHALL write req_write_data to mem[req_address] at that edge, state stays IDLE, no response token generated; back-to-back stores accepted every cycle.
REQ-019 Load transfer in IDLE SHALL latch address; LOAD_LATENCY==1 -> RESPOND next edge; else -> WAIT with 8-bit counter = LOAD_LATENCY-1.
REQ-020 In WAIT counter SHALL decrement each cycle; when counter==1, next state RESPOND; resp_valid rises exactly LOAD_LATENCY cycles after the accepting edge.
REQ-021 resp_data SHALL be loaded with mem[latched address] on the edge entering RESPOND and held stable while resp_stop=1.
REQ-022 RESPOND SHALL hold until response transfer, then return to IDLE next edge; a new request is not accepted in the same cycle as the response transfer.
REQ-023 Read-after-write: a load accepted the cycle after a store to the same address SHALL return the stored value.
REQ-024 Address >= MEM_DEPTH: store SHALL be discarded, load SHALL return 0 with normal timing, error SHALL set on the accepting edge and remain 1 until reset.
REQ-025 req_write, req_address, req_write_data are sampled only at request transfer; values in other cycles SHALL have no effect.
REQ-026 Minimum load throughput SHALL be one load per LOAD_LATENCY+1 cycles with resp_stop=0.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, req_stop 0, resp_valid 0, resp_data 0, error 0, counter 0.
REQ-028 Reset during WAIT or RESPOND SHALL discard the pending load with no response emitted after release.
REQ-029 Memory contents SHALL NOT be reset and SHALL be retained across reset.

Structure
REQ-030 DATA_WIDTH, ADDRESS_WIDTH, LOAD_CYCLE and the 2-bit state encodings (IDLE=00, WAIT=01, RESPOND=10) SHALL live in the shared param.v package.
REQ-031 Storage SHALL be a sub-module elastic_memory_array: synchronous write, combinational read, MEM_DEPTH x DATA_WIDTH.
REQ-032 The FSM, counter, range check and error flag SHALL reside in elastic_memory_port.

Verification
REQ-033 Store 0x0000_00AA to addr 5, then load addr 5 next cycle, LOAD_LATENCY=2 -> resp_valid high 2 cycles after load accept, resp_data=0xAA.
REQ-034 Load with resp_stop held 1 for 4 cycles -> resp_valid and resp_data stable for all 4, req_stop=1 throughout, transfer on release, IDLE next cycle.
REQ-035 Three stores on consecutive cycles to addrs 1,2,3 (values 10,20,30) -> req_stop stays 0; subsequent loads return 10,20,30 in order.
REQ-036 Load addr 1024 with MEM_DEPTH=1024 -> resp_data=0, error=1 and stays 1 after next legal access.
REQ-037 Assert reset_n low during WAIT -> resp_valid 0 immediately, no response after release, mem[5] still reads 0xAA.
REQ-038 LOAD_LATENCY=1, continuous loads with resp_stop=0 -> one response every 2 cycles, resp_valid 1 cycle after each accept.
